// File: rtl/robot_sensor_filter.sv
// ============================================================================
// robot_sensor_filter : sync, prescaled sampling and debounce of wall sensors
// Revision 1.0
// ============================================================================
`default_nettype none

module robot_sensor_filter #(
  parameter int PRESCALE   = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic head_raw,
  input  logic left_raw,
  output logic head,
  output logic left,
  output logic changed,
  output logic sample_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
  localparam logic [PW-1:0] C_PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_STABLE   = CW'(STABLE_CNT);

  // Bit 0 = head channel, bit 1 = left channel.
  logic [1:0]    sync_s1_q, sync_s1_d;
  logic [1:0]    sync_s2_q, sync_s2_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          sample_tick_q, sample_tick_d;
  logic          changed_q, changed_d;
  logic          w_tick;
  logic [1:0]    w_flip;
  logic [1:0]    w_filt;

  always_comb begin
    sync_s1_d     = {left_raw, head_raw};
    sync_s2_d     = sync_s1_q;
    w_tick        = (pre_cnt_q == C_PRE_LAST);
    pre_cnt_d     = w_tick ? '0 : pre_cnt_q + PW'(1);
    sample_tick_d = w_tick;
    changed_d     = |w_flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1_q     <= '0;
      sync_s2_q     <= '0;
      pre_cnt_q     <= '0;
      sample_tick_q <= 1'b0;
      changed_q     <= 1'b0;
    end else begin
      sync_s1_q     <= sync_s1_d;
      sync_s2_q     <= sync_s2_d;
      pre_cnt_q     <= pre_cnt_d;
      sample_tick_q <= sample_tick_d;
      changed_q     <= changed_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;
    logic          flip;

    // Any sample agreeing with the current output discards the pending run.
    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      flip   = 1'b0;
      if (w_tick) begin
        if (sync_s2_q[i] == filt_q) begin
          cnt_d = '0;
        end else if ((cnt_q + CW'(1)) == C_STABLE) begin
          filt_d = sync_s2_q[i];
          cnt_d  = '0;
          flip   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign w_flip[i] = flip;
    assign w_filt[i] = filt_q;
  end

  assign head        = w_filt[0];
  assign left        = w_filt[1];
  assign changed     = changed_q;
  assign sample_tick = sample_tick_q;

endmodule

`default_nettype wire
